// File: rtl/priority_scan_pkg.sv
// Shared types and helpers for the priority scan unit: scan direction,
// controller state and a population count usable at any legal mask width.
package priority_scan_pkg;

  typedef enum logic {
    SCAN_LSB = 1'b0,
    SCAN_MSB = 1'b1
  } scan_dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int BLK_W = 4;
  localparam int MAX_W = 256;
  localparam int POP_W = 9;

  // Callers zero-extend narrower masks to MAX_W before counting.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_W; i++) sum += POP_W'(v[i]);
    return sum;
  endfunction

endpackage

// File: rtl/priority_find_first.sv
// Two-level find-first: 4-bit block encoders feed a block-level priority
// select; the winning block number and its offset form the index.
module priority_find_first
  import priority_scan_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  scan_dir_t        dir,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int NBLK   = (WIDTH + BLK_W - 1) / BLK_W;
  localparam int PAD_W  = NBLK * BLK_W;
  localparam int BNUM_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic [PAD_W-1:0]  padded;
  logic [NBLK-1:0]   blk_valid;
  logic [1:0]        blk_off [NBLK];
  logic [BNUM_W-1:0] win;
  logic [BNUM_W+1:0] idx_full;

  // Padding bits are forced to zero, so they can never win a block.
  assign padded = PAD_W'(mask);

  always_comb begin
    for (int b = 0; b < NBLK; b++) begin
      blk_valid[b] = |padded[b*BLK_W +: BLK_W];
      // NOTE: every combinational output gets a default before any conditional
      // update; a path that leaves it unassigned would infer a latch.
      blk_off[b] = '0;
      for (int k = 0; k < BLK_W; k++) begin
        if (dir == SCAN_LSB) begin
          if (padded[b*BLK_W + (BLK_W-1-k)]) blk_off[b] = 2'(BLK_W-1-k);
        end else begin
          if (padded[b*BLK_W + k]) blk_off[b] = 2'(k);
        end
      end
    end
  end

  // The last qualifying block visited overwrites earlier ones, so the
  // visiting order encodes priority.
  always_comb begin
    win = '0;
    for (int b = 0; b < NBLK; b++) begin
      if (dir == SCAN_LSB) begin
        if (blk_valid[NBLK-1-b]) win = BNUM_W'(NBLK-1-b);
      end else begin
        if (blk_valid[b]) win = BNUM_W'(b);
      end
    end
  end

  assign any      = |blk_valid;
  assign idx_full = {win, blk_off[win]};
  assign idx      = IDX_W'(idx_full);

endmodule

// File: rtl/priority_scan_unit.sv
// Sequential priority scanner: accepts a request mask and emits the index of
// each set bit, one per beat, in LSB-first or MSB-first order.
module priority_scan_unit
  import priority_scan_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [CNT_W-1:0] out_remaining
);

  scan_state_t      state;
  logic [WIDTH-1:0] mask_q;
  scan_dir_t        dir_q;
  logic             empty_q;

  logic [IDX_W-1:0] first_idx;
  logic             first_any;
  logic [CNT_W-1:0] remaining;
  logic             scanning;
  logic             fire;
  logic             accept;

  priority_find_first #(.WIDTH(WIDTH)) u_find (
    .mask (mask_q),
    .dir  (dir_q),
    .idx  (first_idx),
    .any  (first_any)
  );

  assign remaining = CNT_W'(popcount(MAX_W'(mask_q)));

  // All beat outputs read as zero while reset is held.
  assign scanning      = (state == SCAN) && !rst;
  assign out_valid     = scanning && !flush;
  assign out_idx       = scanning ? first_idx : '0;
  assign out_remaining = scanning ? remaining : '0;
  assign out_last      = scanning && (remaining <= CNT_W'(1));
  assign out_empty     = scanning && empty_q;

  assign fire     = out_valid && out_ready;
  assign in_ready = !rst && !flush && ((state == IDLE) || (fire && out_last));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is only ever updated with non-blocking
      // assignments so every register samples pre-edge values.
      state   <= IDLE;
      mask_q  <= '0;
      dir_q   <= SCAN_LSB;
      empty_q <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      mask_q <= '0;
    end else begin
      if (fire) begin
        if (first_any) mask_q <= mask_q & ~(WIDTH'(1) << first_idx);
        if (out_last) state <= IDLE;
      end
      // A same-cycle accept on the last beat overrides the return to IDLE.
      if (accept) begin
        mask_q  <= in_mask;
        dir_q   <= scan_dir_t'(in_dir);
        empty_q <= (in_mask == '0);
        state   <= SCAN;
      end
    end
  end

endmodule

// File: tb/tb_priority_scan_unit.sv
// Self-checking bench for priority_scan_unit: a queue-based reference model
// lists the expected beats of every accepted mask and is compared each cycle.
module tb_priority_scan_unit;

  typedef struct {
    int idx;
    bit last;
    int rem;
    bit empty;
  } beat_t;

  typedef struct {
    logic [15:0] m;
    bit          d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mask;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_empty;
  logic [4:0]  out_remaining;

  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [5:0]  p_in_mask;
  logic        p_in_dir;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [2:0]  p_out_idx;
  logic        p_out_last;
  logic        p_out_empty;
  logic [2:0]  p_out_remaining;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t beats[$];
  req_t  pend[$];

  priority_scan_unit #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mask       (in_mask),
    .in_dir        (in_dir),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .out_empty     (out_empty),
    .out_remaining (out_remaining)
  );

  priority_scan_unit #(.WIDTH(6)) dut_pad (
    .clk           (clk),
    .rst           (rst),
    .flush         (p_flush),
    .in_valid      (p_in_valid),
    .in_ready      (p_in_ready),
    .in_mask       (p_in_mask),
    .in_dir        (p_in_dir),
    .out_valid     (p_out_valid),
    .out_ready     (p_out_ready),
    .out_idx       (p_out_idx),
    .out_last      (p_out_last),
    .out_empty     (p_out_empty),
    .out_remaining (p_out_remaining)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for one mask: the set-bit positions listed in scan order.
  task automatic push_beats(input logic [255:0] m, input int w, input bit d);
    int ids[$];
    int n;
    for (int i = 0; i < w; i++) begin
      int j;
      j = d ? (w - 1 - i) : i;
      if (m[j]) ids.push_back(j);
    end
    n = ids.size();
    if (n == 0) beats.push_back('{idx: 0, last: 1'b1, rem: 0, empty: 1'b1});
    else
      for (int k = 0; k < n; k++)
        beats.push_back('{idx: ids[k], last: (k == n - 1), rem: n - k, empty: 1'b0});
  endtask

  // mode 0: out_ready always 1; 1: out_ready from pat bit per cycle;
  // 2: random out_ready and random in_valid gaps.
  task automatic run_stream(input int mode, input logic [31:0] pat, input string name);
    int          cyc;
    bit          iv, orr, exp_rdy;
    beat_t       b;
    logic [11:0] obs, e;
    cyc = 0;
    while ((pend.size() > 0 || beats.size() > 0) && cyc < 20000) begin
      iv  = (pend.size() > 0) && (mode != 2 || $urandom_range(3) != 0);
      orr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc < 32) ? pat[cyc] : 1'b1)
                                             : 1'($urandom_range(1));
      in_valid  = iv;
      in_mask   = iv ? pend[0].m : 16'($urandom);
      in_dir    = iv ? pend[0].d : 1'($urandom);
      out_ready = orr;
      #1;
      exp_rdy = (beats.size() == 0) || (orr && beats[0].last);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL %s in_ready cycle %0d: got %b expected %b", name, cyc, in_ready, exp_rdy);
      end
      if (beats.size() > 0) begin
        b   = beats[0];
        obs = {out_valid, out_idx, out_last, out_empty, out_remaining};
        e   = {1'b1, 4'(b.idx), b.last, b.empty, 5'(b.rem)};
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL %s beat cycle %0d: got v/idx/last/empty/rem=%b/%0d/%b/%b/%0d expected 1/%0d/%b/%b/%0d",
                   name, cyc, out_valid, out_idx, out_last, out_empty, out_remaining,
                   b.idx, b.last, b.empty, b.rem);
        end
        if (orr) void'(beats.pop_front());
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL %s idle cycle %0d: got out_valid=%b expected 0", name, cyc, out_valid);
        end
      end
      if (iv && exp_rdy) begin
        push_beats(256'(pend[0].m), 16, pend[0].d);
        void'(pend.pop_front());
      end
      step();
      cyc++;
    end
    if (cyc >= 20000) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d cycles expected fewer than 20000", name, cyc);
      pend.delete();
      beats.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL %s end idle: got valid/ready=%b/%b expected 0/1", name, out_valid, in_ready);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_mask = 16'hFFFF; out_ready = 1'b1;
    p_in_valid = 1'b1; p_in_mask = 6'h3F; p_out_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if ({in_ready, out_valid, out_idx, out_last, out_empty, out_remaining} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset16 outputs: got rdy/v/idx/last/empty/rem=%b/%b/%0d/%b/%b/%0d expected all 0",
               in_ready, out_valid, out_idx, out_last, out_empty, out_remaining);
    end
    n_cmp++;
    if ({p_in_ready, p_out_valid, p_out_idx, p_out_last, p_out_empty, p_out_remaining} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset6 outputs: got %b expected all 0",
               {p_in_ready, p_out_valid, p_out_idx, p_out_last, p_out_empty, p_out_remaining});
    end
    rst = 1'b0; in_valid = 1'b0; p_in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset idle: got valid/ready=%b/%b expected 0/1", out_valid, in_ready);
    end
    step();
  endtask

  task automatic test_lsb_basic();
    pend.push_back('{16'h8421, 1'b0});
    run_stream(0, 32'hFFFF_FFFF, "lsb_basic");
  endtask

  task automatic test_msb_stall();
    // Ready per cycle: accept, then 1,0,1,1,1 across the beats.
    pend.push_back('{16'h8421, 1'b1});
    run_stream(1, 32'hFFFF_FFFB, "msb_stall");
  endtask

  task automatic test_empty();
    pend.push_back('{16'h0000, 1'b0});
    pend.push_back('{16'h0000, 1'b1});
    run_stream(0, 32'hFFFF_FFFF, "empty");
  endtask

  task automatic test_back_to_back();
    pend.push_back('{16'h0003, 1'b0});
    pend.push_back('{16'h8000, 1'b0});
    pend.push_back('{16'h0000, 1'b1});
    pend.push_back('{16'h0180, 1'b1});
    run_stream(0, 32'hFFFF_FFFF, "back_to_back");
  endtask

  task automatic test_abort(input bit use_rst, input string name);
    beat_t       b;
    logic [11:0] obs, e;
    beats.delete();
    in_valid = 1'b1; in_mask = 16'hFFFF; in_dir = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept: got in_ready=%b expected 1", name, in_ready);
    end
    push_beats(256'(16'hFFFF), 16, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (2) begin
      #1;
      b   = beats.pop_front();
      obs = {out_valid, out_idx, out_last, out_empty, out_remaining};
      e   = {1'b1, 4'(b.idx), b.last, b.empty, 5'(b.rem)};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s pre-abort beat: got %b expected %b", name, obs, e);
      end
      step();
    end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    in_valid = 1'b1; in_mask = 16'h00F0;
    #1;
    n_cmp++;
    if (use_rst) begin
      if ({in_ready, out_valid, out_idx, out_last, out_empty, out_remaining} !== 13'd0) begin
        n_bad++;
        $display("FAIL %s during reset: got rdy/v/idx/last/empty/rem=%b/%b/%0d/%b/%b/%0d expected all 0",
                 name, in_ready, out_valid, out_idx, out_last, out_empty, out_remaining);
      end
    end else begin
      if ({in_ready, out_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL %s during flush: got ready/valid=%b/%b expected 0/0", name, in_ready, out_valid);
      end
    end
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    beats.delete();
    pend.push_back('{16'h1248, 1'b1});
    run_stream(0, 32'hFFFF_FFFF, name);
  endtask

  task automatic pad_one(input logic [5:0] m, input bit d);
    beat_t      b;
    logic [8:0] obs, e;
    beats.delete();
    push_beats(256'(m), 6, d);
    p_in_valid = 1'b1; p_in_mask = m; p_in_dir = d; p_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (p_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pad accept mask %b: got in_ready=%b expected 1", m, p_in_ready);
    end
    step();
    p_in_valid = 1'b0; p_in_mask = 6'h3F; p_in_dir = ~d;
    while (beats.size() > 0) begin
      #1;
      b   = beats.pop_front();
      obs = {p_out_valid, p_out_idx, p_out_last, p_out_empty, p_out_remaining};
      e   = {1'b1, 3'(b.idx), b.last, b.empty, 3'(b.rem)};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL pad mask %b dir %b beat: got v/idx/last/empty/rem=%b/%0d/%b/%b/%0d expected 1/%0d/%b/%b/%0d",
                 m, d, p_out_valid, p_out_idx, p_out_last, p_out_empty, p_out_remaining,
                 b.idx, b.last, b.empty, b.rem);
      end
      step();
    end
    #1;
    n_cmp++;
    if (p_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pad mask %b end: got out_valid=%b expected 0", m, p_out_valid);
    end
    step();
  endtask

  task automatic test_padding();
    pad_one(6'b100000, 1'b0);
    pad_one(6'b100000, 1'b1);
    for (int m = 0; m < 64; m++) pad_one(6'(m), 1'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [15:0] m;
      case ($urandom_range(3))
        0:       m = 16'h0000;
        1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: m = 16'($urandom);
      endcase
      pend.push_back('{m, 1'($urandom)});
    end
    run_stream(2, 32'h0, "random");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_mask = '0; in_dir = 1'b0; out_ready = 1'b0;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_mask = '0; p_in_dir = 1'b0; p_out_ready = 1'b0;
    test_reset();
    test_lsb_basic();
    test_msb_stall();
    test_empty();
    test_back_to_back();
    test_abort(1'b0, "flush");
    test_abort(1'b1, "reset_abort");
    test_padding();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_scan_unit.md
Name: priority_scan_unit

Overview:
Parametrised, sequential successor to the combinational priority encoder. It accepts a request mask through a valid/ready handshake and emits the index of every set bit, one per output beat. Scan order is selectable per mask: LSB-first or MSB-first. Used for free-list allocation, physical-register release, and load/store-multiple sequencing in the core.

Parameters:
WIDTH, 64, mask width in bits; legal values are 2..256. Non-multiples of 4 are zero-padded internally.
IDX_W, $clog2(WIDTH), width of index output (derived; do not override).
CNT_W, $clog2(WIDTH+1), width of remaining-count output (derived).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of the current scan
in_valid  input  1  new mask offered
in_ready  output  1  unit can accept a mask this cycle
in_mask  input  WIDTH  request bit vector
in_dir  input  1  0 = LSB-first, 1 = MSB-first
out_valid  output  1  out_idx is valid
out_ready  input  1  downstream consumes the current beat
out_idx  output  IDX_W  index of the current highest-priority set bit
out_last  output  1  current beat is the final beat for this mask
out_empty  output  1  loaded mask was all-zero (single beat, no index)
out_remaining  output  CNT_W  popcount of bits not yet consumed, including the current beat

Behaviour:
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SCAN: out_valid = 1.
- Reset (rst = 1 at edge):
  - state = IDLE, mask_q = 0, dir_q = 0, empty_q = 0.
  - While rst is high: in_ready = 0, out_valid = 0, out_idx = 0, out_last = 0, out_empty = 0, out_remaining = 0.
- Accept (in_valid & in_ready):
  - Load mask_q = in_mask, dir_q = in_dir, empty_q = (in_mask == 0).
  - Go to SCAN.
  - First out_valid appears the next cycle (1-cycle load latency).
- In SCAN, outputs are combinational from registered state:
  - out_idx = first set bit of mask_q in dir_q order.
  - out_remaining = popcount(mask_q).
  - out_last = (out_remaining <= 1).
  - out_empty = empty_q.
- Empty mask: exactly one beat with out_empty = 1, out_last = 1, out_idx = 0, out_remaining = 0.
- Output fire (out_valid & out_ready):
  - Clear bit out_idx in mask_q.
  - If out_last: return to IDLE, unless a new mask is accepted in the same cycle.
- Back-to-back: in_ready = IDLE | (out_valid & out_ready & out_last).
  - This creates a combinational path out_ready -> in_ready, which is permitted.
  - A mask accepted on the last-beat fire loads directly, and the state stays SCAN.
  - Throughput is one index per cycle with no bubble between masks.
- Stall: while out_valid & !out_ready, out_idx, out_last, out_empty and out_remaining are held unchanged.
- Flush:
  - flush = 1 forces in_ready = 0 and out_valid = 0 combinationally.
  - At the edge: state = IDLE, mask_q = 0. Any out_ready is ignored, and no accept occurs.
  - Precedence: rst over flush, flush over accept/fire.
- Scan structure: two-level search.
  - 4-bit block encoders produce a block-valid flag and a 2-bit offset.
  - A block-level priority select in dir_q order picks the winning block.
  - out_idx = {block_number, offset}, truncated to IDX_W.
  - Padding bits are never reported.
- in_dir is sampled only at accept; changing it mid-scan has no effect.

Decomposition:
- Package priority_scan_pkg:
  - typedef scan_dir_t (enum: SCAN_LSB = 0, SCAN_MSB = 1).
  - typedef scan_state_t (IDLE, SCAN).
  - localparam BLK_W = 4.
  - Helper function popcount.
- One sub-module, priority_find_first #(WIDTH):
  - Combinational; takes mask and dir; returns idx and any.
  - Built from the 4-bit block stage plus the block select.
  - Instantiated once on mask_q.

Test Plan:
- WIDTH=16, in_mask=16'h8421, dir=LSB, out_ready=1:
  - Accept at cycle 0.
  - out_idx 0, 5, 10, 15 on cycles 1–4.
  - out_remaining 4, 3, 2, 1.
  - out_last only on idx 15; in_ready high on cycle 4.
- Same mask, dir=MSB, out_ready toggling 1,0,1,1,1:
  - Sequence 15, 10, 5, 0.
  - idx 10 held for 2 cycles during the stall, with out_remaining held at 3.
- in_mask=0: one beat, out_empty=1, out_last=1, out_remaining=0; then IDLE.
- Back-to-back: mask 16'h0003 then 16'h8000 offered with in_valid held.
  - Beats 0, 1, 15 on consecutive cycles, with no bubble.
  - Second accept coincides with the idx-1 fire.
- Mid-scan events with mask 16'hFFFF:
  - flush on the 3rd beat: out_valid=0 that cycle, IDLE next cycle, a new mask accepted the following cycle.
  - Repeat with rst asserted instead of flush: all outputs 0, in_ready=0 during reset.
- WIDTH=6 (padding), mask 6'b100000, dir=LSB: single beat, idx=5, out_last=1; bits 6–7 are never reported.
